// File: rtl/l2_response_queue_pkg.sv
// Shared L2 response definitions: packet layout plus the queue sizing that the
// request arbiter and the response queue must agree on.
package l2_response_queue_pkg;

  localparam int unsigned NUM_CORES          = 4;
  localparam int unsigned CORE_ID_WIDTH      = $clog2(NUM_CORES);
  localparam int unsigned CACHE_LINE_BITS    = 512;
  localparam int unsigned L1_WAY_INDEX_WIDTH = 2;
  localparam int unsigned L2_ADDR_WIDTH      = 32;
  localparam int unsigned L2RSP_STATUS_WIDTH = 2;

  // The arbiter holds back L2_PIPE_STAGES slots for responses still in flight.
  localparam int unsigned L2RSP_QUEUE_DEPTH  = 8;
  localparam int unsigned L2_PIPE_STAGES     = 4;

  typedef enum logic [1:0] {
    L2RSP_LOAD_ACK      = 2'd0,
    L2RSP_STORE_ACK     = 2'd1,
    L2RSP_WRITEBACK_ACK = 2'd2,
    L2RSP_FLUSH_ACK     = 2'd3
  } l2rsp_packet_type_t;

  typedef struct packed {
    logic                                valid;
    l2rsp_packet_type_t                  packet_type;
    logic [CORE_ID_WIDTH-1:0]            core;
    logic [L2_ADDR_WIDTH-1:0]            address;
    logic                                update;
    logic [L1_WAY_INDEX_WIDTH-1:0]       way;
    logic [CACHE_LINE_BITS-1:0]          data;
    logic [L2RSP_STATUS_WIDTH-1:0]       status;
  } l2rsp_packet_t;

endpackage

// File: rtl/l2_response_queue_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and occupancy count.
// Storage is not reset; only control state is.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/l2_response_queue.sv
// Elastic buffer behind the L2 response stage: in-order delivery under
// valid/ready, early almost-full back-pressure and a sticky drop flag.
module l2_response_queue
  import l2_response_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = L2RSP_QUEUE_DEPTH,
  parameter int unsigned PIPE_RESERVE = L2_PIPE_STAGES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  l2rsp_packet_t          l2rsp_packet,
  output l2rsp_packet_t          out_packet,
  input  logic                   out_ready,
  output logic                   queue_almost_full,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow_error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $bits(l2rsp_packet_t);

  logic [PW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          r_overflow;

  assign w_pop  = !w_empty && out_ready;
  assign w_push = l2rsp_packet.valid && (!w_full || w_pop);
  assign w_drop = l2rsp_packet.valid && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (l2rsp_packet),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Unreset storage may hold stale lines; never expose them while empty.
  always_comb begin
    out_packet = '0;
    if (!w_empty) begin
      out_packet = l2rsp_packet_t'(w_head);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign queue_almost_full = (w_count >= CW'(DEPTH - PIPE_RESERVE));
  assign queue_count       = w_count;
  assign overflow_error    = r_overflow;

endmodule

// File: tb/tb_l2_response_queue.sv
// Directed self-checking bench for l2_response_queue with a small in-order
// scoreboard for the streaming phase.
module tb_l2_response_queue;
  import l2_response_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned PW    = $bits(l2rsp_packet_t);

  logic          clk;
  logic          reset_n;
  l2rsp_packet_t l2rsp_packet;
  l2rsp_packet_t out_packet;
  logic          out_ready;
  logic          queue_almost_full;
  logic [CW-1:0] queue_count;
  logic          overflow_error;

  int n_checks = 0;
  int n_errors = 0;

  l2_response_queue #(.DEPTH(DEPTH), .PIPE_RESERVE(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .l2rsp_packet      (l2rsp_packet),
    .out_packet        (out_packet),
    .out_ready         (out_ready),
    .queue_almost_full (queue_almost_full),
    .queue_count       (queue_count),
    .overflow_error    (overflow_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A dropped packet must always be flagged on the following cycle.
  property p_drop_flagged;
    @(posedge clk) disable iff (!reset_n)
      (l2rsp_packet.valid && queue_count == CW'(DEPTH) && !out_ready) |=> overflow_error;
  endproperty
  a_drop_flagged: assert property (p_drop_flagged);

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic l2rsp_packet_t mk_pkt(input int i);
    l2rsp_packet_t p;
    p.valid       = 1'b1;
    p.packet_type = l2rsp_packet_type_t'(2'(i));
    p.core        = CORE_ID_WIDTH'(i + 1);
    p.address     = 32'h1000 + 32'(i) * 32'd64;
    p.update      = 1'(i);
    p.way         = 2'(i >> 1);
    p.data        = {16{32'hC0DE0000 | 32'(i)}};
    p.status      = 2'(i + 1);
    return p;
  endfunction

  l2rsp_packet_t p0;
  l2rsp_packet_t mq[$];
  l2rsp_packet_t exp_head;
  int            sent;
  int            cyc;
  logic          do_push;
  logic          do_pop;

  initial begin
    reset_n      = 1'b0;
    out_ready    = 1'b0;
    l2rsp_packet = '0;
    #12;
    chk("rst_count", PW'(queue_count), PW'(0));
    chk("rst_out", out_packet, '0);
    chk("rst_af", PW'(queue_almost_full), PW'(0));
    chk("rst_ovf", PW'(overflow_error), PW'(0));
    reset_n = 1'b1;

    // Single STORE_ACK packet, consumer ready.
    p0             = '0;
    p0.valid       = 1'b1;
    p0.packet_type = L2RSP_STORE_ACK;
    p0.core        = CORE_ID_WIDTH'(1);
    p0.address     = 32'h40;
    p0.data        = {64{8'hA5}};
    l2rsp_packet   = p0;
    out_ready      = 1'b1;
    chk("single_pre_valid", PW'(out_packet.valid), PW'(0));
    tick();
    chk("single_out", out_packet, p0);
    chk("single_cnt1", PW'(queue_count), PW'(1));
    l2rsp_packet = '0;
    tick();
    chk("single_cnt0", PW'(queue_count), PW'(0));
    chk("single_out_zero", out_packet, '0);
    out_ready = 1'b0;

    // Fill without drain.
    for (int i = 0; i < 8; i++) begin
      l2rsp_packet = mk_pkt(i);
      tick();
      chk("fill_cnt", PW'(queue_count), PW'(i + 1));
      chk("fill_af", PW'(queue_almost_full), PW'((i + 1) >= 4));
      chk("fill_head", out_packet, mk_pkt(0));
    end
    l2rsp_packet = '0;
    tick();
    chk("fill_hold_head", out_packet, mk_pkt(0));

    // Full with simultaneous push and pop.
    out_ready    = 1'b1;
    l2rsp_packet = mk_pkt(8);
    tick();
    chk("fullpp_cnt", PW'(queue_count), PW'(8));
    chk("fullpp_ovf", PW'(overflow_error), PW'(0));
    chk("fullpp_head", out_packet, mk_pkt(1));
    out_ready    = 1'b0;

    // Overflow: push into a full queue that is not draining.
    l2rsp_packet = mk_pkt(99);
    tick();
    chk("ovf_set", PW'(overflow_error), PW'(1));
    chk("ovf_cnt", PW'(queue_count), PW'(8));
    chk("ovf_head", out_packet, mk_pkt(1));
    l2rsp_packet = '0;
    tick();
    chk("ovf_sticky", PW'(overflow_error), PW'(1));

    // Drain: packets 1..8, never the dropped one.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", out_packet, mk_pkt(i));
      tick();
    end
    chk("drain_cnt", PW'(queue_count), PW'(0));
    chk("drain_out_zero", out_packet, '0);
    chk("drain_ovf_sticky", PW'(overflow_error), PW'(1));

    // Streaming with random consumer back-pressure across pointer wrap.
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || mq.size() != 0) && cyc < 400) begin
      out_ready    = 1'($urandom_range(0, 1));
      do_push      = (sent < 20) && (mq.size() < DEPTH);
      l2rsp_packet = do_push ? mk_pkt(100 + sent) : '0;
      exp_head     = (mq.size() != 0) ? mq[0] : '0;
      chk("stream_head", out_packet, exp_head);
      do_pop = (mq.size() != 0) && out_ready;
      tick();
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(mk_pkt(100 + sent));
        sent++;
      end
      chk("stream_cnt", PW'(queue_count), PW'(mq.size()));
      chk("stream_af", PW'(queue_almost_full), PW'(mq.size() >= 4));
      cyc++;
    end
    chk("stream_done", PW'(sent == 20 && mq.size() == 0), PW'(1));
    l2rsp_packet = '0;
    out_ready    = 1'b0;

    // Reset mid-operation with five packets queued.
    for (int i = 0; i < 5; i++) begin
      l2rsp_packet = mk_pkt(200 + i);
      tick();
    end
    l2rsp_packet = '0;
    chk("mid_cnt5", PW'(queue_count), PW'(5));
    chk("mid_af_pre", PW'(queue_almost_full), PW'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cnt", PW'(queue_count), PW'(0));
    chk("mid_rst_out", out_packet, '0);
    chk("mid_rst_af", PW'(queue_almost_full), PW'(0));
    chk("mid_rst_ovf", PW'(overflow_error), PW'(0));
    #3;
    reset_n      = 1'b1;
    l2rsp_packet = mk_pkt(300);
    chk("post_rst_empty", out_packet, '0);
    tick();
    chk("post_rst_out", out_packet, mk_pkt(300));
    chk("post_rst_cnt", PW'(queue_count), PW'(1));
    l2rsp_packet = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
